// File: rtl/result_retire_pkg.sv
// ============================================================================
// Module      : result_retire_pkg
// Description : Shared widths, constants, stage record type and address-match
//               helper for the result retire pipe and its GPR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_retire_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Shared control/bus constants
  localparam logic          RstEnable    = 1'b1;
  localparam logic          WriteEnable  = 1'b1;
  localparam logic          WriteDisable = 1'b0;
  localparam logic          ReadEnable   = 1'b1;
  localparam logic [DW-1:0] ZeroWord     = '0;
  localparam int            RegNum       = NREG;
  localparam logic [AW-1:0] NOPRegAddr   = '0;

  typedef logic [DW-1:0] reg_bus_t;
  typedef logic [AW-1:0] reg_addr_bus_t;

  // One in-flight result as carried by each retire stage
  typedef struct packed {
    logic          wreg;
    reg_addr_bus_t wd;
    reg_bus_t      wdata;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '{wreg: WriteDisable, wd: NOPRegAddr, wdata: ZeroWord};

  // A pending result matches a read when it writes, targets the same
  // register, and that register is not the hardwired zero.
  function automatic logic addr_hit(input stage_t s, input reg_addr_bus_t ra);
    return (s.wreg == WriteEnable) && (s.wd == ra) && (ra != NOPRegAddr);
  endfunction

endpackage : result_retire_pkg

`default_nettype wire

// File: rtl/result_retire_if.sv
// ============================================================================
// Module      : result_retire_if
// Description : Result / operand-read / commit-trace bundle between the
//               execution and decode side (master) and the retire pipe (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface result_retire_if;
  import result_retire_pkg::*;

  // Result from the execution stage
  logic [AW-1:0] ex_wd_i;
  logic          ex_wreg_i;
  logic [DW-1:0] ex_wdata_i;

  // Pipe control
  logic          stall_i;
  logic          flush_i;

  // Decode-stage operand reads
  logic          re1_i;
  logic [AW-1:0] raddr1_i;
  logic [DW-1:0] rdata1_o;
  logic          re2_i;
  logic [AW-1:0] raddr2_i;
  logic [DW-1:0] rdata2_o;
  logic          hazard_o;

  // Commit trace from stage 2
  logic [AW-1:0] wb_wd_o;
  logic          wb_wreg_o;
  logic [DW-1:0] wb_wdata_o;

  modport master (
    output ex_wd_i, ex_wreg_i, ex_wdata_i,
    output stall_i, flush_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, hazard_o,
    input  wb_wd_o, wb_wreg_o, wb_wdata_o
  );

  modport slave (
    input  ex_wd_i, ex_wreg_i, ex_wdata_i,
    input  stall_i, flush_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, hazard_o,
    output wb_wd_o, wb_wreg_o, wb_wdata_o
  );

endinterface : result_retire_if

`default_nettype wire

// File: rtl/result_retire_gpr_file.sv
// ============================================================================
// Module      : result_retire_gpr_file
// Description : General purpose register file. One synchronous write port,
//               two asynchronous read ports, r0 hardwired to zero, all
//               registers cleared synchronously on rst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_retire_gpr_file
  import result_retire_pkg::*;
#(
  parameter int NREGS  = RegNum,
  parameter int ADDR_W = AW,
  parameter int DATA_W = DW
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [ADDR_W-1:0] i_raddr1,
  output logic      [DATA_W-1:0] o_rdata1,
  input  wire logic [ADDR_W-1:0] i_raddr2,
  output logic      [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] w_regs [NREGS];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      // r0 has no storage; it always reads as zero
      assign w_regs[gi] = '0;
    end else begin : g_live
      logic [DATA_W-1:0] r_q;

      // Per-register storage: cleared by reset, loaded when addressed
      always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
          r_q <= '0;
        end else if (i_we == WriteEnable && i_waddr == ADDR_W'(gi)) begin
          r_q <= i_wdata;
        end
      end

      assign w_regs[gi] = r_q;
    end
  end

  assign o_rdata1 = w_regs[i_raddr1];
  assign o_rdata2 = w_regs[i_raddr2];

endmodule : result_retire_gpr_file

`default_nettype wire

// File: rtl/result_retire.sv
// ============================================================================
// Module      : result_retire
// Description : Two-stage result retire pipe (EX/MEM -> MEM/WB -> GPR file)
//               with decode-stage operand reads. Configuration macro
//               RESULT_FWD_EN: when defined, pending results are forwarded
//               to the read ports (youngest first) and hazard_o is tied 0;
//               when undefined, reads come from the GPR array only and a
//               pending matching result raises hazard_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_retire
  import result_retire_pkg::*;
(
  input wire logic        clk,
  input wire logic        rst,
  result_retire_if.slave  bus
);

  stage_t   r_s1;
  stage_t   r_s2;
  stage_t   w_ex;
  logic     w_gpr_we;
  reg_bus_t w_gpr_rd1;
  reg_bus_t w_gpr_rd2;
  reg_bus_t w_rdata1;
  reg_bus_t w_rdata2;
  logic     w_hazard;

  assign w_ex.wreg  = bus.ex_wreg_i;
  assign w_ex.wd    = bus.ex_wd_i;
  assign w_ex.wdata = bus.ex_wdata_i;

  // Stage registers: flush beats stall beats advance; a stall holds stage 1
  // and lets stage 2 drain into a bubble.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_s1 <= STAGE_EMPTY;
      r_s2 <= STAGE_EMPTY;
    end else if (bus.flush_i) begin
      r_s1 <= STAGE_EMPTY;
      r_s2 <= STAGE_EMPTY;
    end else if (bus.stall_i) begin
      r_s2 <= STAGE_EMPTY;
    end else begin
      r_s1 <= w_ex;
      r_s2 <= r_s1;
    end
  end

  // Stage 2 commits on the edge it is held, independent of flush on that edge
  assign w_gpr_we = (r_s2.wreg == WriteEnable) && (r_s2.wd != NOPRegAddr);

  result_retire_gpr_file u_gpr (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_gpr_we),
    .i_waddr  (r_s2.wd),
    .i_wdata  (r_s2.wdata),
    .i_raddr1 (bus.raddr1_i),
    .o_rdata1 (w_gpr_rd1),
    .i_raddr2 (bus.raddr2_i),
    .o_rdata2 (w_gpr_rd2)
  );

  // Resolve one read port: disabled, r0 and reset all give zero; otherwise
  // the youngest matching pending result wins when forwarding is built in.
  function automatic reg_bus_t sel_read(
    input logic          re,
    input reg_addr_bus_t ra,
    input reg_bus_t      gpr,
    input stage_t        ex,
    input stage_t        s1,
    input stage_t        s2
  );
    reg_bus_t d;
    d = ZeroWord;
    if (re == ReadEnable && ra != NOPRegAddr) begin
`ifdef RESULT_FWD_EN
      if (addr_hit(ex, ra)) begin
        d = ex.wdata;
      end else if (addr_hit(s1, ra)) begin
        d = s1.wdata;
      end else if (addr_hit(s2, ra)) begin
        d = s2.wdata;
      end else begin
        d = gpr;
      end
`else
      d = gpr;
`endif
    end
    return d;
  endfunction

  // A port is blocked while any younger-than-GPR result targets its register
  function automatic logic port_blocked(
    input logic          re,
    input reg_addr_bus_t ra,
    input stage_t        ex,
    input stage_t        s1,
    input stage_t        s2
  );
    return (re == ReadEnable) &&
           (addr_hit(ex, ra) || addr_hit(s1, ra) || addr_hit(s2, ra));
  endfunction

  // Read-port data and hazard, forced quiet while reset is asserted
  always_comb begin
    w_rdata1 = ZeroWord;
    w_rdata2 = ZeroWord;
    w_hazard = 1'b0;
    if (rst != RstEnable) begin
      w_rdata1 = sel_read(bus.re1_i, bus.raddr1_i, w_gpr_rd1, w_ex, r_s1, r_s2);
      w_rdata2 = sel_read(bus.re2_i, bus.raddr2_i, w_gpr_rd2, w_ex, r_s1, r_s2);
`ifdef RESULT_FWD_EN
      w_hazard = 1'b0;
`else
      w_hazard = port_blocked(bus.re1_i, bus.raddr1_i, w_ex, r_s1, r_s2) ||
                 port_blocked(bus.re2_i, bus.raddr2_i, w_ex, r_s1, r_s2);
`endif
    end
  end

`ifdef RESULT_FWD_EN
  // The stall-check helper is only meaningful without forwarding
  logic w_unused_blocked;
  assign w_unused_blocked = port_blocked(1'b0, NOPRegAddr, STAGE_EMPTY, STAGE_EMPTY, STAGE_EMPTY);
`endif

  assign bus.rdata1_o   = w_rdata1;
  assign bus.rdata2_o   = w_rdata2;
  assign bus.hazard_o   = w_hazard;
  assign bus.wb_wd_o    = r_s2.wd;
  assign bus.wb_wreg_o  = r_s2.wreg;
  assign bus.wb_wdata_o = r_s2.wdata;

endmodule : result_retire

`default_nettype wire

// File: tb/tb_result_retire.sv
// ============================================================================
// Module      : tb_result_retire
// Description : Self-checking bench for result_retire. Committed results are
//               predicted into a queue when presented and matched against
//               the wb_* trace; operand reads are checked directly.
//               Expectations follow RESULT_FWD_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_retire;

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] data;
  } commit_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  commit_t exp_q[$];

  result_retire_if bus();

  result_retire dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Commit monitor: every stage-2 write strobe must match the oldest prediction
  always @(negedge clk) begin
    if (!rst && bus.wb_wreg_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        chk("wb_wd", {27'd0, bus.wb_wd_o}, {27'd0, e.wd});
        chk("wb_wdata", bus.wb_wdata_o, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] wd, input logic [31:0] data, input bit expect_commit);
    bus.ex_wreg_i  = 1'b1;
    bus.ex_wd_i    = wd;
    bus.ex_wdata_i = data;
    if (expect_commit) exp_q.push_back('{wd: wd, data: data});
  endtask

  task automatic idle_ex();
    bus.ex_wreg_i  = 1'b0;
    bus.ex_wd_i    = 5'd0;
    bus.ex_wdata_i = 32'd0;
  endtask

  task automatic rd(input int port, input logic [4:0] a, input logic [31:0] exp,
                    input logic exp_hz, input string tag);
    if (port == 1) begin
      bus.re1_i = 1'b1; bus.raddr1_i = a;
    end else begin
      bus.re2_i = 1'b1; bus.raddr2_i = a;
    end
    #1;
    chk(tag, (port == 1) ? bus.rdata1_o : bus.rdata2_o, exp);
    chk({tag, "_hz"}, {31'd0, bus.hazard_o}, {31'd0, exp_hz});
    bus.re1_i = 1'b0;
    bus.re2_i = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle_ex();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.re1_i = 1'b0; bus.raddr1_i = 5'd0;
    bus.re2_i = 1'b0; bus.raddr2_i = 5'd0;

    // 1. Reset
    step(); step();
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd4;
    present(5'd4, 32'hDEAD_BEEF, 1'b0);
    #1;
    chk("rst_rdata1", bus.rdata1_o, 32'd0);
    chk("rst_hazard", {31'd0, bus.hazard_o}, 32'd0);
    chk("rst_wb_wreg", {31'd0, bus.wb_wreg_o}, 32'd0);
    idle_ex();
    bus.re1_i = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_wb_wd", {27'd0, bus.wb_wd_o}, 32'd0);
    chk("rst_wb_wdata", bus.wb_wdata_o, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.re1_i = 1'b1; bus.raddr1_i = 5'(i);
      bus.re2_i = 1'b1; bus.raddr2_i = 5'(31 - i);
      #1;
      chk("rst_reg_p1", bus.rdata1_o, 32'd0);
      chk("rst_reg_p2", bus.rdata2_o, 32'd0);
      chk("rst_reg_hz", {31'd0, bus.hazard_o}, 32'd0);
    end
    bus.re1_i = 1'b0; bus.re2_i = 1'b0;

    // 2. Single result reaches wb on cycle 2, GPR from cycle 3
    step();
    present(5'd3, 32'h1234_5678, 1'b1);
    step(); idle_ex();
    chk("t2_wb_c1", {31'd0, bus.wb_wreg_o}, 32'd0);
    step();
    chk("t2_wb_wreg", {31'd0, bus.wb_wreg_o}, 32'd1);
    chk("t2_wb_wd", {27'd0, bus.wb_wd_o}, 32'd3);
    step();
    rd(1, 5'd3, 32'h1234_5678, 1'b0, "t2_r3");
    step();
    rd(1, 5'd3, 32'h1234_5678, 1'b0, "t2_r3_later");

    // 3. Read-after-write on r5
    present(5'd5, 32'hA5A5_0000, 1'b1);
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd5;
    #1;
`ifdef RESULT_FWD_EN
    chk("t3_fwd_ex", bus.rdata1_o, 32'hA5A5_0000);
    chk("t3_fwd_hz", {31'd0, bus.hazard_o}, 32'd0);
    step(); idle_ex(); #1;
    chk("t3_fwd_s1", bus.rdata1_o, 32'hA5A5_0000);
    step(); #1;
    chk("t3_fwd_s2", bus.rdata1_o, 32'hA5A5_0000);
    step(); #1;
`else
    chk("t3_hz_ex", {31'd0, bus.hazard_o}, 32'd1);
    step(); idle_ex(); #1;
    chk("t3_hz_s1", {31'd0, bus.hazard_o}, 32'd1);
    step(); #1;
    chk("t3_hz_s2", {31'd0, bus.hazard_o}, 32'd1);
    step(); #1;
`endif
    chk("t3_gpr", bus.rdata1_o, 32'hA5A5_0000);
    chk("t3_gpr_hz", {31'd0, bus.hazard_o}, 32'd0);
    bus.re1_i = 1'b0;

    // 3b. Youngest pending result wins
    present(5'd5, 32'd1, 1'b1);
    step();
    present(5'd5, 32'd2, 1'b1);
    step(); idle_ex();
`ifdef RESULT_FWD_EN
    rd(2, 5'd5, 32'd2, 1'b0, "t3_youngest");
`else
    rd(2, 5'd5, 32'hA5A5_0000, 1'b1, "t3_youngest_hz");
`endif
    step(); step();
    rd(2, 5'd5, 32'd2, 1'b0, "t3_youngest_gpr");

    // 4. Write to r0 is traced but dropped
    present(5'd0, 32'hFFFF_FFFF, 1'b1);
    rd(2, 5'd0, 32'd0, 1'b0, "t4_r0_ex");
    step(); idle_ex();
    step(); step(); step();
    rd(1, 5'd0, 32'd0, 1'b0, "t4_r0_after");

    // 5. Stall holds stage 1 and bubbles stage 2
    present(5'd9, 32'h0000_000A, 1'b1);
    step(); idle_ex();
    bus.stall_i = 1'b1;
    step();
    chk("t5_stall_c1", {31'd0, bus.wb_wreg_o}, 32'd0);
    step();
    chk("t5_stall_c2", {31'd0, bus.wb_wreg_o}, 32'd0);
    bus.stall_i = 1'b0;
    step();
    chk("t5_release", {31'd0, bus.wb_wreg_o}, 32'd1);
    step();
    chk("t5_once", {31'd0, bus.wb_wreg_o}, 32'd0);
    rd(1, 5'd9, 32'h0000_000A, 1'b0, "t5_r9");

    // 5b. Stall together with flush clears everything
    present(5'd10, 32'h0000_000B, 1'b0);
    step(); idle_ex();
    bus.stall_i = 1'b1; bus.flush_i = 1'b1;
    step();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    chk("t5_flush_c1", {31'd0, bus.wb_wreg_o}, 32'd0);
    step();
    chk("t5_flush_c2", {31'd0, bus.wb_wreg_o}, 32'd0);
    step();
    rd(1, 5'd10, 32'd0, 1'b0, "t5_r10");

    // 5c. Flush on the commit edge does not cancel the write
    present(5'd11, 32'h0000_0C0C, 1'b1);
    step(); idle_ex();
    step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    rd(2, 5'd11, 32'h0000_0C0C, 1'b0, "t5_r11");

    // 6. Back-to-back writes to r7
    present(5'd7, 32'd1, 1'b1);
    step();
    present(5'd7, 32'd2, 1'b1);
    step();
    present(5'd7, 32'd3, 1'b1);
    step(); idle_ex();
    step(); step();
    rd(1, 5'd7, 32'd3, 1'b0, "t6_r7");
    step(); step();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_result_retire

`default_nettype wire
